// File: rtl/wb_pkg.sv
// Shared constants and bundle types for the write-back arbiter.
// Exports XLEN, REG_ADDR_W, STAT_W, wb_req_t and rf_wr_t.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int STAT_W     = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef struct packed {
    logic                  write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: first set req_i bit at or after ptr_i.
// Ports: req_i, ptr_i in; gnt_o (one-hot), idx_o, any_o out.
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter for the register bank's single write port.
// Ports: clk, rst_h (async, active-high), req_valid/req_rd/req_data in,
// req_ready, rf_write/rf_rd/rf_write_data, busy out; grant_count with WB_STATS_EN.
module wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst_h,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_write,
  output logic [REG_ADDR_W-1:0]         rf_rd,
  output logic [XLEN-1:0]               rf_write_data,
  output logic                          busy
`ifdef WB_STATS_EN
  ,
  output logic [NUM_REQ*wb_pkg::STAT_W-1:0] grant_count
`endif
);

  import wb_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      win_idx;
  logic               any;
  wb_req_t            win;
  rf_wr_t             rf_q, rf_d;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (any)
  );

  always_comb begin
    win.rd   = req_rd[int'(win_idx)*REG_ADDR_W +: REG_ADDR_W];
    win.data = req_data[int'(win_idx)*XLEN +: XLEN];
  end

  // rd==0 still consumes the grant; only the bank write is suppressed.
  always_comb begin
    ptr_d      = ptr_q;
    rf_d       = rf_q;
    rf_d.write = 1'b0;
    if (any) begin
      rf_d.write = (win.rd != '0);
      rf_d.rd    = win.rd;
      rf_d.data  = win.data;
      if (win_idx == PW'(NUM_REQ-1))
        ptr_d = '0;
      else
        ptr_d = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      ptr_q <= '0;
      rf_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      rf_q  <= rf_d;
    end
  end

  assign req_ready     = gnt;
  assign rf_write      = rf_q.write;
  assign rf_rd         = rf_q.rd;
  assign rf_write_data = rf_q.data;
  assign busy          = (|req_valid) | rf_q.write;

`ifdef WB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      for (int i = 0; i < NUM_REQ; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_count[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with a negedge-commit bank model.
// Exercises grant_count only when WB_STATS_EN is defined.
module tb_wb_arbiter;

  logic        clk   = 1'b0;
  logic        rst_h = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [4:0]  rd_v  [3] = '{default: '0};
  logic [31:0] dat_v [3] = '{default: '0};
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic        busy;
`ifdef WB_STATS_EN
  logic [47:0] grant_count;
`endif

  logic [31:0] bank [32] = '{default: '0};

  int checks   = 0;
  int failures = 0;

  assign req_rd   = {rd_v[2], rd_v[1], rd_v[0]};
  assign req_data = {dat_v[2], dat_v[1], dat_v[0]};

  always #5 clk = ~clk;

  // Bank model writes whatever it is told, so an x0 write would show.
  always @(negedge clk)
    if (rf_write) bank[rf_rd] <= rf_write_data;

  wb_arbiter #(
    .NUM_REQ    (3),
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk           (clk),
    .rst_h         (rst_h),
    .req_valid     (req_valid),
    .req_rd        (req_rd),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_write      (rf_write),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .busy          (busy)
`ifdef WB_STATS_EN
    ,
    .grant_count   (grant_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_write", 32'(rf_write), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_h = 1'b0;

    // single request
    req_valid = 3'b001; rd_v[0] = 5'd5; dat_v[0] = 32'hDEADBEEF;
    #1;
    chk("single_ready", 32'(req_ready), 32'b001);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    req_valid = 3'b000;
    chk("single_write", 32'(rf_write), 32'd1);
    chk("single_rd", 32'(rf_rd), 32'd5);
    chk("single_data", rf_write_data, 32'hDEADBEEF);
    chk("single_busy2", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("single_bank5", bank[5], 32'hDEADBEEF);
    chk("idle_ready", 32'(req_ready), 32'd0);

    // x0 drop
    req_valid = 3'b100; rd_v[2] = 5'd0; dat_v[2] = 32'h1234;
    #1;
    chk("x0_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = 3'b000;
    chk("x0_write", 32'(rf_write), 32'd0);
    chk("x0_data", rf_write_data, 32'h1234);
    @(negedge clk); #1;
    chk("x0_bank0", bank[0], 32'd0);

    // round-robin from ptr=0
    rd_v[0] = 5'd1; rd_v[1] = 5'd2; rd_v[2] = 5'd3;
    dat_v[0] = 32'hA1; dat_v[1] = 32'hA2; dat_v[2] = 32'hA3;
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk($sformatf("rr_write%0d", k), 32'(rf_write), 32'd1);
      chk($sformatf("rr_rd%0d", k), 32'(rf_rd), 32'(k % 3 + 1));
      chk($sformatf("rr_data%0d", k), rf_write_data, 32'(32'hA1 + k % 3));
    end
    req_valid = 3'b000;

    // same rd from two requesters, starting at ptr=1
    req_valid = 3'b001; rd_v[0] = 5'd9; dat_v[0] = 32'h99;
    #1;
    tick();
    req_valid = 3'b110;
    rd_v[1] = 5'd7; dat_v[1] = 32'h11;
    rd_v[2] = 5'd7; dat_v[2] = 32'h22;
    #1;
    chk("same_ready1", 32'(req_ready), 32'b010);
    tick();
    chk("same_data1", rf_write_data, 32'h11);
    chk("same_rd1", 32'(rf_rd), 32'd7);
    req_valid = 3'b100;
    #1;
    chk("same_ready2", 32'(req_ready), 32'b100);
    @(negedge clk); #1;
    chk("same_bank7a", bank[7], 32'h11);
    tick();
    chk("same_data2", rf_write_data, 32'h22);
    req_valid = 3'b000;
    @(negedge clk); #1;
    chk("same_bank7b", bank[7], 32'h22);

    // reset mid-operation discards a pending write and clears ptr
    req_valid = 3'b001; rd_v[0] = 5'd4; dat_v[0] = 32'h55;
    rd_v[2] = 5'd6; dat_v[2] = 32'h66;
    #1;
    tick();
    chk("pre_rst_write", 32'(rf_write), 32'd1);
    req_valid = 3'b101;
    #1;
    rst_h = 1'b1;
    #1;
    chk("mid_rst_write", 32'(rf_write), 32'd0);
    chk("mid_rst_rd", 32'(rf_rd), 32'd0);
    chk("mid_rst_data", rf_write_data, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("mid_rst_bank4", bank[4], 32'd0);
    rst_h = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b001);
    tick();
    chk("post_rst_rd", 32'(rf_rd), 32'd4);
    chk("post_rst_data", rf_write_data, 32'h55);
    req_valid = 3'b000;

`ifdef WB_STATS_EN
    #1;
    rst_h = 1'b1;
    #1;
    chk("gc_rst0", 32'(grant_count[15:0]), 32'd0);
    chk("gc_rst1", 32'(grant_count[31:16]), 32'd0);
    chk("gc_rst2", 32'(grant_count[47:32]), 32'd0);
    rst_h = 1'b0;
    rd_v[0] = 5'd0;
    req_valid = 3'b001;
    repeat (10) @(posedge clk);
    #1;
    chk("gc_ten", 32'(grant_count[15:0]), 32'd10);
    repeat (69990) @(posedge clk);
    #1;
    req_valid = 3'b000;
    chk("gc_sat0", 32'(grant_count[15:0]), 32'hFFFF);
    chk("gc_sat1", 32'(grant_count[31:16]), 32'd0);
    chk("gc_sat2", 32'(grant_count[47:32]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter for the 32x32 register bank's single write port.
- Shares the port between NUM_REQ write-back sources (ALU, load unit, mul/div) using round-robin arbitration with a valid/ready handshake.
- Registers the winning request and drives the bank's write, rd and write_data inputs one cycle after acceptance.
- The bank commits the write on the following negedge.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- XLEN, 32, data width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_h  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  request i has a pending write.
- req_rd  in  NUM_REQ x REG_ADDR_W  destination register of request i.
- req_data  in  NUM_REQ x XLEN  write data of request i.
- req_ready  out  NUM_REQ  grant; request i is accepted on a cycle with req_valid[i] && req_ready[i].
- rf_write  out  1  to register bank write.
- rf_rd  out  REG_ADDR_W  to register bank rd.
- rf_write_data  out  XLEN  to register bank write_data.
- busy  out  1  any req_valid high, or rf_write high.
- grant_count  out  NUM_REQ x 16  per-requester accepted-grant counters; present only with WB_STATS_EN.

Behaviour:
- State:
  - round-robin pointer ptr (clog2(NUM_REQ) bits).
  - output registers rf_write, rf_rd, rf_write_data.
  - optional counters.
- Reset (async, rst_h=1): ptr=0, rf_write=0, rf_rd=0, rf_write_data=0, grant_count=0. req_ready and busy follow their combinational definitions.
- Arbitration (combinational, cycle N):
  - winner = first i with req_valid[i], searching ptr, ptr+1, ... with wrap from NUM_REQ-1 to 0.
  - req_ready is one-hot on the winner, all-zero if no request is valid.
  - req_ready depends on req_valid. Requesters must not derive valid from ready.
  - Requesters hold valid, rd and data stable until accepted.
- Accept (posedge ending cycle N):
  - If a winner exists: rf_rd<=req_rd[w], rf_write_data<=req_data[w], rf_write<=(req_rd[w]!=0), ptr<=(w+1) mod NUM_REQ.
  - If no winner: rf_write<=0; rf_rd and rf_write_data hold; ptr holds.
- Latency: accept in cycle N; rf_write high during cycle N+1; bank updated at the negedge inside cycle N+1. Readable via rs1/rs2 in the second half of N+1.
- Throughput: one write per cycle. Back-to-back grants are allowed with no bubble.
- rd==0: the request is accepted and consumes its grant (ptr advances), but rf_write stays 0. x0 is never written.
- Fairness: a continuously valid request is granted within NUM_REQ cycles (at most NUM_REQ-1 other grants first).
- Same rd from two requesters: writes land in grant order; the later-granted data is final.
- Reset mid-operation: a registered but not-yet-committed write is discarded (rf_write forced 0). Unaccepted requests remain owned by the requesters.
- busy is combinational: OR of req_valid plus rf_write.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined:
  - grant_count[i] increments by 1 on each accepted request i, including rd==0 requests.
  - Counter width is 16 and saturates at 16'hFFFF.
  - Cleared only by rst_h.
- Undefined: the grant_count port and its counters are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg:
  - XLEN, REG_ADDR_W, STAT_W=16 constants.
  - typedef wb_req_t (struct: rd, data).
  - typedef rf_wr_t (struct: write, rd, data).
- Sub-module rr_picker: purely combinational rotate-priority encoder (inputs req vector and ptr; outputs one-hot grant, winner index, any).
- wb_arbiter holds all sequential state.

Test Plan:
- Reset: drive traffic, assert rst_h mid-cycle -> rf_write, rf_rd, rf_write_data = 0 immediately; ptr=0; first post-reset grant goes to the lowest valid index.
- Single request: req0 rd=5, data=32'hDEADBEEF -> req_ready=3'b001 in the same cycle; next cycle rf_write=1, rf_rd=5, rf_write_data=32'hDEADBEEF; bank reg5 reads DEADBEEF after the negedge.
- Round-robin: all three valid continuously from ptr=0 -> grant sequence 0,1,2,0,1,2; rf_write high every cycle; each req_ready high once per 3 cycles.
- x0 drop: req2 rd=0, data=32'h1234 -> req_ready[2]=1; next cycle rf_write=0; ptr advances to 0.
- Same-rd ordering: ptr=1; req1 rd=7 data=32'h11 and req2 rd=7 data=32'h22 held valid -> rf writes 0x11 then 0x22; reg7 ends at 0x22.
- Stats (WB_STATS_EN): 70000 accepted req0 grants -> grant_count[0]=16'hFFFF, others 0. Without the macro, the bench compiles with no grant_count port.
